// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU/load/issue inputs, decode queries and register-file write port
interface writeback_arbiter_if #(parameter int XLEN = 32);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_result;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            busy1;
    logic            busy2;
    logic            reg_write;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic            idle;
    modport master (
        output alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data,
               issue_valid, issue_rd, rs1, rs2,
        input  mem_ready, issue_ready, busy1, busy2, reg_write, write_reg, write_data, idle
    );
    modport slave (
        input  alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data,
               issue_valid, issue_rd, rs1, rs2,
        output mem_ready, issue_ready, busy1, busy2, reg_write, write_reg, write_data, idle
    );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and buffered load results onto the register-file write port
module writeback_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic reset,
    writeback_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [4:0]      fifo_rd   [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [31:0]     pend, set_mask, clr_mask;
    logic            push, pop, alu_req, mem_ready, issue_ready;
    logic            reg_write;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    always_comb begin
        mem_ready   = !reset && count != FULL;
        issue_ready = !pend[bus.issue_rd] || bus.issue_rd == 5'd0;
        alu_req     = bus.alu_valid && bus.alu_rd != 5'd0;
        // pop sees registered count, so a load pushed this cycle cannot leave until the next
        pop         = !alu_req && count != '0;
        push        = bus.mem_valid && mem_ready && bus.mem_rd != 5'd0;
        set_mask    = (bus.issue_valid && issue_ready && bus.issue_rd != 5'd0) ? 32'd1 << bus.issue_rd : '0;
        clr_mask    = pop ? 32'd1 << fifo_rd[rd_ptr] : '0;
    end
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.mem_rd;
            fifo_data[wr_ptr] <= bus.mem_data;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pend       <= '0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
            pend      <= (pend & ~clr_mask) | set_mask;
            reg_write <= alu_req || pop;
            if (alu_req) begin
                write_reg  <= bus.alu_rd;
                write_data <= bus.alu_result;
            end else if (pop) begin
                write_reg  <= fifo_rd[rd_ptr];
                write_data <= fifo_data[rd_ptr];
            end
        end
    end
    assign bus.mem_ready   = mem_ready;
    assign bus.issue_ready = issue_ready;
    assign bus.busy1       = pend[bus.rs1] && bus.rs1 != 5'd0;
    assign bus.busy2       = pend[bus.rs2] && bus.rs2 != 5'd0;
    assign bus.reg_write   = reg_write;
    assign bus.write_reg   = write_reg;
    assign bus.write_data  = write_data;
    assign bus.idle        = count == '0 && pend == '0;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: queue-based model plus write scoreboard for writeback_arbiter
module tb_writeback_arbiter;
    logic clk = 1'b0;
    logic reset;
    int n_checks = 0;
    int n_fail = 0;
    logic [36:0] mfifo[$];
    logic [36:0] sb[$];
    logic [31:0] pend_m;
    writeback_arbiter_if #(.XLEN(32)) bus();
    writeback_arbiter #(.XLEN(32), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_result = 0;
        bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
        bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    endtask

    // one clock with the inputs currently driven; model predicts, DUT is compared
    task automatic tick();
        logic alu_req, mready, iready, pop;
        logic [36:0] e;
        logic [31:0] set_m;
        #1;
        mready = mfifo.size() != 4;
        iready = !pend_m[bus.issue_rd] || bus.issue_rd == 0;
        check("mem_ready", bus.mem_ready, mready);
        check("issue_ready", bus.issue_ready, iready);
        check("busy1", bus.busy1, pend_m[bus.rs1] && bus.rs1 != 0);
        check("busy2", bus.busy2, pend_m[bus.rs2] && bus.rs2 != 0);
        check("idle", bus.idle, mfifo.size() == 0 && pend_m == 0);
        alu_req = bus.alu_valid && bus.alu_rd != 0;
        pop = !alu_req && mfifo.size() != 0;
        set_m = (bus.issue_valid && iready && bus.issue_rd != 0) ? 32'd1 << bus.issue_rd : 32'd0;
        if (alu_req) sb.push_back({bus.alu_rd, bus.alu_result});
        else if (pop) begin
            e = mfifo.pop_front();
            sb.push_back(e);
            pend_m[e[36:32]] = 1'b0;
        end
        if (bus.mem_valid && mready && bus.mem_rd != 0) mfifo.push_back({bus.mem_rd, bus.mem_data});
        pend_m |= set_m;
        @(posedge clk);
        #1;
        check("reg_write", bus.reg_write, alu_req || pop);
        if (bus.reg_write && sb.size() != 0) begin
            e = sb.pop_front();
            check("write_reg", bus.write_reg, e[36:32]);
            check("write_data", bus.write_data, e[31:0]);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        clear_inputs();
        #1;
        check("rst_mem_ready_now", bus.mem_ready, 0);
        repeat (n) @(posedge clk);
        #1;
        check("rst_reg_write", bus.reg_write, 0);
        check("rst_write_reg", bus.write_reg, 0);
        check("rst_write_data", bus.write_data, 0);
        check("rst_idle", bus.idle, 1);
        check("rst_mem_ready", bus.mem_ready, 0);
        reset = 1'b0;
        mfifo.delete();
        sb.delete();
        pend_m = '0;
    endtask

    initial begin
        do_reset(2);
        // single ALU write, one-cycle latency, then hold
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_result = 32'hDEADBEEF;
        tick();
        check("alu_data", bus.write_data, 32'hDEADBEEF);
        clear_inputs();
        tick();
        check("alu_hold_reg", bus.write_reg, 5);
        // issue then load to rd 7, scoreboard set and cleared
        bus.issue_valid = 1; bus.issue_rd = 7;
        tick();
        clear_inputs();
        bus.rs1 = 7; bus.rs2 = 7;
        #1;
        check("busy1_set", bus.busy1, 1);
        bus.mem_valid = 1; bus.mem_rd = 7; bus.mem_data = 32'h11;
        tick();
        check("ld_not_yet", bus.reg_write, 0);
        bus.mem_valid = 0;
        tick();
        check("ld7_reg", bus.write_reg, 7);
        check("ld7_data", bus.write_data, 32'h11);
        check("busy1_clr", bus.busy1, 0);
        check("idle_after_ld", bus.idle, 1);
        clear_inputs();
        // ALU stream with 4 loads arriving behind it
        for (int i = 0; i < 6; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'(10 + i); bus.alu_result = 32'h1000 + i;
            bus.mem_valid = 1; bus.mem_rd = 5'(i + 1); bus.mem_data = 32'hA1 + i;
            if (i == 4) begin
                #1;
                check("full_mem_ready", bus.mem_ready, 0);
            end
            tick();
        end
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ld_order_reg", bus.write_reg, 5'(i + 1));
            check("ld_order_data", bus.write_data, 32'hA1 + i);
        end
        tick();
        // duplicate issue of rd 9
        bus.issue_valid = 1; bus.issue_rd = 9;
        tick();
        #1;
        check("dup_issue_ready", bus.issue_ready, 0);
        tick();
        clear_inputs();
        bus.mem_valid = 1; bus.mem_rd = 9; bus.mem_data = 32'h99;
        tick();
        clear_inputs();
        tick();
        check("ld9_reg", bus.write_reg, 9);
        check("idle_after_9", bus.idle, 1);
        // alu_rd 0 yields to FIFO head; mem_rd 0 is swallowed
        bus.alu_valid = 1; bus.alu_rd = 12; bus.alu_result = 32'hC;
        bus.mem_valid = 1; bus.mem_rd = 6; bus.mem_data = 32'h66;
        tick();
        bus.alu_rd = 0; bus.alu_result = 32'hBAD; bus.mem_valid = 0;
        tick();
        check("x0_head_reg", bus.write_reg, 6);
        check("x0_head_data", bus.write_data, 32'h66);
        clear_inputs();
        bus.mem_valid = 1; bus.mem_rd = 0; bus.mem_data = 32'h77;
        tick();
        clear_inputs();
        tick();
        check("rd0_no_write", bus.reg_write, 0);
        check("rd0_idle", bus.idle, 1);
        // reset with 3 buffered loads and pend[3]
        for (int i = 0; i < 3; i++) begin
            bus.issue_valid = i == 0; bus.issue_rd = 3;
            bus.alu_valid = 1; bus.alu_rd = 20; bus.alu_result = 32'h20 + i;
            bus.mem_valid = 1; bus.mem_rd = 5'(i + 1); bus.mem_data = 32'hB0 + i;
            tick();
        end
        check("pre_rst_idle", bus.idle, 0);
        do_reset(2);
        bus.rs1 = 3;
        tick();
        check("post_rst_busy", bus.busy1, 0);
        // randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            bus.alu_valid = 1'($urandom_range(0, 1));
            bus.alu_rd = 5'($urandom_range(0, 7));
            bus.alu_result = $urandom;
            bus.mem_valid = 1'($urandom_range(0, 1));
            bus.mem_rd = 5'($urandom_range(0, 7));
            bus.mem_data = $urandom;
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.issue_rd = 5'($urandom_range(0, 7));
            bus.rs1 = 5'($urandom_range(0, 7));
            bus.rs2 = 5'($urandom_range(0, 7));
            tick();
        end
        clear_inputs();
        repeat (8) tick();
        check("sb_drained", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
